ps2_key_decoder: RTL and testbench

Receives raw PS/2 keyboard clock/data lines and produces the 11-bit key event word that the core's input logic consumes: bit 10 toggles on every event, bit 9 is pressed (1) or released (0), bit 8 is the extended flag (E0 prefix), and bits 7:0 are the scan code. It sits between the PS/2 pins (or a bridge that exposes them) and each arcade core's keyboard mapping block. It handles the E0, F0 and E1 prefixes, odd parity, and glitch filtering.

---
 rtl/ps2_key_decoder.sv | 213 +++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the raw lines, frames 11-bit
// PS/2 packets and folds E0/F0/E1 prefixes into an 11-bit key event word.
// Optional frame timeout is enabled by defining PS2_TIMEOUT_EN.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_valid,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [7:0] FILT_MAX = 8'(FILTER_LEN - 1);

  // Index 0 carries the PS/2 clock line, index 1 the PS/2 data line.
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] filt_q, filt_d;
  logic [7:0] filtCnt_q [2];
  logic [7:0] filtCnt_d [2];
  logic       clkPrev_q;
  logic       fall;
  logic       sample;

  state_t      state_q, state_d;
  logic [2:0]  bitCnt_q, bitCnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        parity_q, parity_d;
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic [2:0]  skipCnt_q, skipCnt_d;
  logic [10:0] key_q, key_d;
  logic        keyValid_q, keyValid_d;
  logic        frameErr_q, frameErr_d;
  logic        frameOk;
  logic        timeoutHit;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= {ps2_data, ps2_clk};
      sync2_q <= sync1_q;
    end
  end

  // A line's filtered level flips only after FILTER_LEN consecutive disagreeing cycles.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i]    = filt_q[i];
      filtCnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (filtCnt_q[i] == FILT_MAX) begin
          filt_d[i] = sync2_q[i];
        end else begin
          filtCnt_d[i] = filtCnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      filt_q       <= 2'b11;
      filtCnt_q[0] <= '0;
      filtCnt_q[1] <= '0;
      clkPrev_q    <= 1'b1;
    end else begin
      filt_q       <= filt_d;
      filtCnt_q[0] <= filtCnt_d[0];
      filtCnt_q[1] <= filtCnt_d[1];
      clkPrev_q    <= filt_q[0];
    end
  end

  assign fall   = clkPrev_q & ~filt_q[0];
  assign sample = filt_q[1];

`ifdef PS2_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] toCnt_q, toCnt_d;

  // Idle-time counter: reloads on every sampled edge, frozen at zero while IDLE.
  always_comb begin
    timeoutHit = 1'b0;
    toCnt_d    = toCnt_q + 1'b1;
    if (fall || state_q == IDLE) begin
      toCnt_d = '0;
    end else if (toCnt_q == TO_LAST) begin
      timeoutHit = 1'b1;
      toCnt_d    = '0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      toCnt_q <= '0;
    end else begin
      toCnt_q <= toCnt_d;
    end
  end
`else
  // Without the timeout a partial frame simply waits; the comparison is constant false.
  assign timeoutHit = (TIMEOUT_CYCLES < 0);
`endif

  // Frame FSM and byte handler; a completed frame is consumed on the stop-bit edge.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shreg_d    = shreg_q;
    parity_d   = parity_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    skipCnt_d  = skipCnt_q;
    key_d      = key_q;
    keyValid_d = 1'b0;
    frameErr_d = 1'b0;
    frameOk    = sample && ((^shreg_q) ^ parity_q);

    if (timeoutHit) begin
      state_d    = IDLE;
      frameErr_d = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!sample) begin
            state_d  = DATA;
            bitCnt_d = '0;
          end
        end
        DATA: begin
          shreg_d  = {sample, shreg_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          parity_d = sample;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!frameOk) begin
            frameErr_d = 1'b1;
            ext_d      = 1'b0;
            brk_d      = 1'b0;
            skipCnt_d  = '0;
          end else if (skipCnt_q != 3'd0) begin
            skipCnt_d = skipCnt_q - 3'd1;
          end else if (shreg_q == 8'hE1) begin
            skipCnt_d = 3'd7;
          end else if (shreg_q == 8'hE0) begin
            ext_d = 1'b1;
          end else if (shreg_q == 8'hF0) begin
            brk_d = 1'b1;
          end else begin
            key_d      = {~key_q[10], ~brk_q, ext_q, shreg_q};
            keyValid_d = 1'b1;
            ext_d      = 1'b0;
            brk_d      = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      skipCnt_q  <= '0;
      key_q      <= '0;
      keyValid_q <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shreg_q    <= shreg_d;
      parity_q   <= parity_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      skipCnt_q  <= skipCnt_d;
      key_q      <= key_d;
      keyValid_q <= keyValid_d;
      frameErr_q <= frameErr_d;
    end
  end

  assign ps2_key   = key_q;
  assign key_valid = keyValid_q;
  assign frame_err = frameErr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives bit-level PS/2 frames and checks the
// event word and pulse counts after each step. Timeout checks follow PS2_TIMEOUT_EN.
module tb_ps2_key_decoder;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 1000;

  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        key_valid;
  logic        frame_err;

  int total = 0;
  int bad   = 0;
  int kvCount = 0;
  int feCount = 0;
  int bothCount = 0;
  int kvBase = 0;
  int feBase = 0;

  ps2_key_decoder #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  // Pulses are tallied on the falling edge, so a two-cycle pulse counts twice.
  always @(negedge clk_sys) begin
    if (key_valid) kvCount <= kvCount + 1;
    if (frame_err) feCount <= feCount + 1;
    if (key_valid && frame_err) bothCount <= bothCount + 1;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic markEvents();
    kvBase = kvCount;
    feBase = feCount;
  endtask

  task automatic checkEvents(input string tag, input int expKv, input int expFe);
    checkOutput({tag, "_kv"}, 32'(kvCount - kvBase), 32'(expKv));
    checkOutput({tag, "_fe"}, 32'(feCount - feBase), 32'(expFe));
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic psBit(input logic b);
    ps2_data = b;
    waitCycles(10);
    ps2_clk = 1'b0;
    waitCycles(20);
    ps2_clk = 1'b1;
    waitCycles(10);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic badParity,
                               input logic stopBit);
    psBit(1'b0);
    for (int i = 0; i < 8; i++) psBit(d[i]);
    psBit((~^d) ^ badParity);
    psBit(stopBit);
    ps2_data = 1'b1;
    waitCycles(20);
  endtask

  task automatic sendByte(input logic [7:0] d);
    applyStimulus(d, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] pauseSeq [8];
    pauseSeq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    waitCycles(5);
    checkOutput("reset_key", 32'(ps2_key), 32'h000);
    checkOutput("reset_kv", 32'(key_valid), 32'd0);
    checkOutput("reset_fe", 32'(frame_err), 32'd0);
    reset_n = 1'b1;
    waitCycles(10);

    markEvents();
    sendByte(8'h1C);
    checkOutput("make_key", 32'(ps2_key), 32'h61C);
    checkEvents("make", 1, 0);

    markEvents();
    sendByte(8'hF0);
    checkEvents("brk_prefix", 0, 0);
    sendByte(8'h1C);
    checkOutput("brk_key", 32'(ps2_key), 32'h01C);
    checkEvents("brk", 1, 0);

    // toggle=1, pressed=1 (no F0 seen), ext=1, code 0x75
    markEvents();
    sendByte(8'hE0);
    sendByte(8'h75);
    checkOutput("ext_key", 32'(ps2_key), 32'h775);
    checkEvents("ext", 1, 0);

    markEvents();
    for (int i = 0; i < 8; i++) sendByte(pauseSeq[i]);
    checkOutput("pause_key", 32'(ps2_key), 32'h775);
    checkEvents("pause", 0, 0);

    markEvents();
    sendByte(8'hE0);
    applyStimulus(8'h29, 1'b1, 1'b1);
    checkEvents("par_err", 0, 1);
    markEvents();
    sendByte(8'h75);
    checkOutput("after_err_key", 32'(ps2_key), 32'h275);
    checkEvents("after_err", 1, 0);

    markEvents();
    applyStimulus(8'h29, 1'b0, 1'b0);
    checkEvents("stop_err", 0, 1);
    markEvents();
    sendByte(8'hF0);
    applyStimulus(8'h29, 1'b0, 1'b0);
    sendByte(8'h29);
    checkOutput("brk_cleared_key", 32'(ps2_key), 32'h629);
    checkEvents("brk_cleared", 1, 1);

    markEvents();
    sendByte(8'hE1);
    sendByte(8'h14);
    applyStimulus(8'h29, 1'b1, 1'b1);
    sendByte(8'h1C);
    checkOutput("skip_cleared_key", 32'(ps2_key), 32'h21C);
    checkEvents("skip_cleared", 1, 1);

    markEvents();
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    waitCycles(FILTER_LEN - 2);
    ps2_clk = 1'b1;
    waitCycles(5);
    ps2_data = 1'b1;
    waitCycles(30);
    checkEvents("short_glitch", 0, 0);
    ps2_clk = 1'b0;
    waitCycles(FILTER_LEN + 3);
    ps2_clk = 1'b1;
    waitCycles(40);
    checkEvents("idle_high_edge", 0, 0);
    sendByte(8'h1C);
    checkOutput("post_glitch_key", 32'(ps2_key), 32'h61C);
    checkEvents("post_glitch", 1, 0);

    psBit(1'b0);
    psBit(1'b1);
    psBit(1'b0);
    reset_n = 1'b0;
    waitCycles(3);
    checkOutput("midreset_key", 32'(ps2_key), 32'h000);
    reset_n = 1'b1;
    waitCycles(10);
    markEvents();
    sendByte(8'h1C);
    checkOutput("after_reset_key", 32'(ps2_key), 32'h61C);
    checkEvents("after_reset", 1, 0);

    psBit(1'b0);
    for (int i = 0; i < 4; i++) psBit(1'b1);
    markEvents();
`ifdef PS2_TIMEOUT_EN
    waitCycles(950);
    checkEvents("timeout_early", 0, 0);
    waitCycles(60);
    checkEvents("timeout", 0, 1);
    markEvents();
    sendByte(8'h1C);
    checkOutput("after_timeout_key", 32'(ps2_key), 32'h21C);
    checkEvents("after_timeout", 1, 0);
`else
    waitCycles(10000);
    checkEvents("no_timeout", 0, 0);
    reset_n = 1'b0;
    waitCycles(3);
    reset_n = 1'b1;
    waitCycles(10);
    markEvents();
    sendByte(8'h1C);
    checkOutput("after_stall_key", 32'(ps2_key), 32'h61C);
    checkEvents("after_stall", 1, 0);
`endif

    checkOutput("no_overlap", 32'(bothCount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
